// File: rtl/usb_token_pkg.sv
// Shared encodings for the USB token generator: token types, PIDs, CRC5 constants, FSM states.
package usb_token_pkg;

    localparam logic [1:0] TOK_OUT   = 2'b00;
    localparam logic [1:0] TOK_IN    = 2'b01;
    localparam logic [1:0] TOK_SOF   = 2'b10;
    localparam logic [1:0] TOK_SETUP = 2'b11;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;

    localparam logic [4:0] CRC5_POLY = 5'h05;
    localparam logic [4:0] CRC5_INIT = 5'h1F;

    typedef enum logic [2:0] {
        StIdle,
        StPid,
        StByte1,
        StByte2,
        StDone
    } state_e;

    // PID byte on the wire carries the check nibble (one's complement) in the upper half.
    function automatic logic [7:0] pid_byte(input logic [1:0] tok);
        logic [3:0] pid;
        case (tok)
            TOK_OUT: pid = PID_OUT;
            TOK_IN:  pid = PID_IN;
            TOK_SOF: pid = PID_SOF;
            default: pid = PID_SETUP;
        endcase
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_crc5.sv
// Combinational USB CRC5 over an 11-bit token field; output is inverted and bit-reversed
// so that it drops straight into byte2[7:3].
module usb_crc5
    import usb_token_pkg::*;
(
    input  logic [10:0] data_i,
    output logic [4:0]  crc_o
);

    logic [4:0] crc;
    logic       fb;

    always_comb begin
        crc = CRC5_INIT;
        fb  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            fb  = data_i[i] ^ crc[4];
            crc = {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        crc_o = ~{crc[0], crc[1], crc[2], crc[3], crc[4]};
    end

endmodule

// File: rtl/usb_token_generator.sv
// Host-side USB token packet builder streaming PID/byte1/byte2 over a UTMI valid/ready port.
// Optional utmi_tx_last output enabled by defining USB_TOKEN_TX_LAST_EN.
module usb_token_generator
    import usb_token_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        token_start,
    input  logic [1:0]  token_type,
    input  logic [6:0]  token_addr,
    input  logic [3:0]  token_endp,
    input  logic [10:0] token_frame,
    output logic        token_ready,
    output logic        token_done,
    output logic [7:0]  utmi_tx_data,
    output logic        utmi_tx_valid,
    input  logic        utmi_tx_ready
`ifdef USB_TOKEN_TX_LAST_EN
    ,
    output logic        utmi_tx_last
`endif
);

    state_e      state_q;
    logic [10:0] field_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ready_q;
    logic        done_q;
    logic [4:0]  crc;
    logic [10:0] field_in;
`ifdef USB_TOKEN_TX_LAST_EN
    logic        last_q;
`endif

    assign field_in = (token_type == TOK_SOF) ? token_frame : {token_endp, token_addr};

    // CRC only matters once byte2 is loaded, so it runs off the latched field.
    usb_crc5 u_crc5 (
        .data_i (field_q),
        .crc_o  (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            field_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef USB_TOKEN_TX_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (token_start) begin
                        field_q <= field_in;
                        data_q  <= pid_byte(token_type);
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StPid;
                    end
                end
                StPid: begin
                    if (utmi_tx_ready) begin
                        data_q  <= field_q[7:0];
                        state_q <= StByte1;
                    end
                end
                StByte1: begin
                    if (utmi_tx_ready) begin
                        data_q  <= {crc, field_q[10:8]};
`ifdef USB_TOKEN_TX_LAST_EN
                        last_q  <= 1'b1;
`endif
                        state_q <= StByte2;
                    end
                end
                StByte2: begin
                    if (utmi_tx_ready) begin
                        data_q  <= 8'h00;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
`ifdef USB_TOKEN_TX_LAST_EN
                        last_q  <= 1'b0;
`endif
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign token_ready   = ready_q;
    assign token_done    = done_q;
    assign utmi_tx_data  = data_q;
    assign utmi_tx_valid = valid_q;
`ifdef USB_TOKEN_TX_LAST_EN
    assign utmi_tx_last  = last_q;
`endif

endmodule

// File: tb/tb_usb_token_generator.sv
// Self-checking bench for usb_token_generator: scoreboard of expected transmit bytes,
// popped by a negedge monitor on every valid&&ready handshake.
module tb_usb_token_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        token_start;
    logic [1:0]  token_type;
    logic [6:0]  token_addr;
    logic [3:0]  token_endp;
    logic [10:0] token_frame;
    logic        token_ready;
    logic        token_done;
    logic [7:0]  utmi_tx_data;
    logic        utmi_tx_valid;
    logic        utmi_tx_ready;
`ifdef USB_TOKEN_TX_LAST_EN
    logic        utmi_tx_last;
`endif

    always #8 clk = ~clk;

    usb_token_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .token_start   (token_start),
        .token_type    (token_type),
        .token_addr    (token_addr),
        .token_endp    (token_endp),
        .token_frame   (token_frame),
        .token_ready   (token_ready),
        .token_done    (token_done),
        .utmi_tx_data  (utmi_tx_data),
        .utmi_tx_valid (utmi_tx_valid),
        .utmi_tx_ready (utmi_tx_ready)
`ifdef USB_TOKEN_TX_LAST_EN
        ,
        .utmi_tx_last  (utmi_tx_last)
`endif
    );

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;

    // Inputs change 2 time units after posedge; the monitor samples at negedge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (token_done === 1'b1) done_cnt++;
            if (hold_pend) begin
                total++;
                if (utmi_tx_valid !== 1'b1 || utmi_tx_data !== hold_data) begin
                    bad++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             utmi_tx_valid, utmi_tx_data, hold_data);
                end
            end
            hold_pend = 1'b0;
`ifdef USB_TOKEN_TX_LAST_EN
            total++;
            if (utmi_tx_last !== (utmi_tx_valid === 1'b1 && exp_q.size() == 1)) begin
                bad++;
                $display("FAIL tx_last: got %b, required %b", utmi_tx_last,
                         (utmi_tx_valid === 1'b1 && exp_q.size() == 1));
            end
`endif
            if (utmi_tx_valid === 1'b1) begin
                if (utmi_tx_ready === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_byte: got %h, required no byte", utmi_tx_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (utmi_tx_data !== e) begin
                            bad++;
                            $display("FAIL tx_byte: got %h, required %h", utmi_tx_data, e);
                        end
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_data = utmi_tx_data;
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    function automatic logic [4:0] model_crc(input logic [10:0] f);
        logic [4:0] c;
        logic       b;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            b = f[i] ^ c[4];
            c = {c[3:0], 1'b0} ^ (b ? 5'h05 : 5'h00);
        end
        return ~{c[0], c[1], c[2], c[3], c[4]};
    endfunction

    function automatic void push_token(input logic [1:0] t, input logic [6:0] a,
                                       input logic [3:0] e, input logic [10:0] fr);
        logic [3:0]  p;
        logic [10:0] f;
        case (t)
            2'b00:   p = 4'h1;
            2'b01:   p = 4'h9;
            2'b10:   p = 4'h5;
            default: p = 4'hD;
        endcase
        f = (t == 2'b10) ? fr : {e, a};
        exp_q.push_back({~p, p});
        exp_q.push_back(f[7:0]);
        exp_q.push_back({model_crc(f), f[10:8]});
    endfunction

    task automatic issue(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e,
                         input logic [10:0] fr);
        token_start = 1'b1;
        token_type  = t;
        token_addr  = a;
        token_endp  = e;
        token_frame = fr;
        step();
        token_start = 1'b0;
        token_type  = 2'($urandom);
        token_addr  = 7'($urandom);
        token_endp  = 4'($urandom);
        token_frame = 11'($urandom);
        total++;
        if (utmi_tx_valid !== 1'b1 || utmi_tx_data !== exp_q[0] || token_ready !== 1'b0) begin
            bad++;
            $display("FAIL pid_latency: valid=%b data=%h ready=%b, required 1 %h 0",
                     utmi_tx_valid, utmi_tx_data, token_ready, exp_q[0]);
        end
    endtask

    // mode 0: ready held high, 1: ready toggles starting low, 2: random ready.
    task automatic finish_token(input int mode, input logic poke);
        int   n;
        logic seen;
        seen = 1'b0;
        for (n = 0; n < 80; n++) begin
            case (mode)
                0:       utmi_tx_ready = 1'b1;
                1:       utmi_tx_ready = n[0];
                default: utmi_tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke) begin
                token_start = 1'b1;
                token_type  = 2'($urandom);
                token_addr  = 7'($urandom);
                token_endp  = 4'($urandom);
                token_frame = 11'($urandom);
            end
            step();
            if (token_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        token_start   = 1'b0;
        utmi_tx_ready = 1'b1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: no token_done within budget, required a pulse");
        end
        if (mode == 0) begin
            total++;
            if (n != 2) begin
                bad++;
                $display("FAIL done_latency: done after %0d cycles, required 2", n);
            end
        end
        total++;
        if (token_ready !== 1'b0 || utmi_tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_state: ready=%b valid=%b, required 0 0", token_ready,
                     utmi_tx_valid);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d bytes outstanding, required 0", exp_q.size());
        end
        step();
        total++;
        if (token_done !== 1'b0 || token_ready !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse: done=%b ready=%b, required 0 1", token_done, token_ready);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        token_start   = 1'b0;
        token_type    = 2'b00;
        token_addr    = '0;
        token_endp    = '0;
        token_frame   = '0;
        utmi_tx_ready = 1'b1;
        step();
        step();
        total++;
        if (token_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b, required 1", token_ready);
        end
        total++;
        if (token_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b, required 0", token_done);
        end
        total++;
        if (utmi_tx_valid !== 1'b0 || utmi_tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx: valid=%b data=%h, required 0 00", utmi_tx_valid,
                     utmi_tx_data);
        end
`ifdef USB_TOKEN_TX_LAST_EN
        total++;
        if (utmi_tx_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_last: got %b, required 0", utmi_tx_last);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_setup();
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h10);
        issue(2'b11, 7'd0, 4'd0, 11'd0);
        finish_token(0, 1'b0);
    endtask

    task automatic test_in();
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h58);
        issue(2'b01, 7'd1, 4'd1, 11'd0);
        finish_token(0, 1'b0);
    endtask

    task automatic test_sof();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h7B);
        exp_q.push_back(8'h10);
        issue(2'b10, 7'h55, 4'hA, 11'd123);
        finish_token(0, 1'b0);
    endtask

    task automatic test_out_throttled();
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'hF9);
        utmi_tx_ready = 1'b0;
        issue(2'b00, 7'd5, 4'd2, 11'd0);
        finish_token(1, 1'b0);
    endtask

    task automatic test_start_ignored();
        push_token(2'b01, 7'h3A, 4'd7, 11'd0);
        issue(2'b01, 7'h3A, 4'd7, 11'd0);
        finish_token(2, 1'b1);
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h10);
        utmi_tx_ready = 1'b1;
        issue(2'b11, 7'd0, 4'd0, 11'd0);
        step();
        rst_n = 1'b0;
        total++;
        if (exp_q.size() != 2) begin
            bad++;
            $display("FAIL mid_pid_accepted: %0d bytes left, required 2", exp_q.size());
        end
        step();
        exp_q.delete();
        total++;
        if (utmi_tx_valid !== 1'b0 || token_ready !== 1'b1 || token_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid=%b ready=%b done=%b, required 0 1 0",
                     utmi_tx_valid, token_ready, token_done);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (done_cnt != d0 || token_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_done: done pulses %0d, required %0d", done_cnt, d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t;
        logic [6:0]  a;
        logic [3:0]  e;
        logic [10:0] fr;
        for (int k = 0; k < 6; k++) begin
            t  = 2'($urandom);
            a  = 7'($urandom);
            e  = 4'($urandom);
            fr = 11'($urandom);
            push_token(t, a, e, fr);
            issue(t, a, e, fr);
            finish_token(k % 3, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_in();
        test_sof();
        test_out_throttled();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_token_generator.md
Name: usb_token_generator

Overview:
- Host-side USB token packet builder: turns a token request (OUT/IN/SOF/SETUP plus address/endpoint or frame number) into the 3-byte token packet PID, byte1, byte2, with CRC5 computed.
- Streams the bytes over a UTMI-style 8-bit transmit valid/ready interface.
- Sits between the host transaction scheduler and the UTMI PHY transmit path.

Parameters:
- None. All widths are fixed by the USB 2.0 token format.

Ports:
- clk  input  1  system clock, 60 MHz UTMI clock domain
- rst_n  input  1  reset, synchronous, active-low
- token_start  input  1  request pulse; sampled only while token_ready=1
- token_type  input  2  00=OUT, 01=IN, 10=SOF, 11=SETUP
- token_addr  input  7  device address; ignored for SOF
- token_endp  input  4  endpoint number; ignored for SOF
- token_frame  input  11  frame number; used only for SOF
- token_ready  output  1  high when idle and able to accept token_start
- token_done  output  1  one-cycle pulse after the last byte is accepted
- utmi_tx_data  output  8  transmit byte
- utmi_tx_valid  output  1  utmi_tx_data is valid
- utmi_tx_ready  input  1  PHY accepts the byte when valid&&ready at a rising clk edge

Behaviour:
- Single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, token_ready=1, token_done=0, utmi_tx_valid=0, utmi_tx_data=8'h00.
- Reset asserted mid-packet aborts the packet. The block returns to IDLE with valid low the edge after reset is sampled. No done pulse is generated.
- FSM states: IDLE, PID, BYTE1, BYTE2, DONE.
- IDLE: token_ready=1. On token_start=1, latch type/addr/endp/frame, compute the 11-bit field and CRC5, then go to PID.
- Latency: start sampled at edge N gives valid=1 with the PID byte during cycle N+1.
- PID, BYTE1 and BYTE2 each drive valid=1 with their byte. Advance to the next state only on a valid&&ready edge. While ready=0, data and valid hold stable.
- After the BYTE2 handshake go to DONE. DONE lasts one cycle with token_done=1, valid=0 and token_ready=0, then returns to IDLE.
- token_start outside IDLE is ignored. Request inputs may change after the start cycle because they are latched.
- PID byte is {~pid[3:0], pid[3:0]}: OUT=0xE1, IN=0x69, SOF=0xA5, SETUP=0x2D.
- 11-bit field:
  - OUT/IN/SETUP: field = {endp[3:0], addr[6:0]}.
  - SOF: field = frame[10:0].
- Byte formats:
  - byte1 = field[7:0].
  - byte2 = {crc_tx[4:0], field[10:8]}.
- CRC5 computation:
  - Polynomial x^5+x^2+1 (0x05), register initialised to 5'b11111.
  - Field bits are processed LSB first: fb = bit ^ crc[4]; crc = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 0).
  - The result is inverted, then bit-reversed into the byte: byte2[3]=~crc[4], byte2[4]=~crc[3], byte2[5]=~crc[2], byte2[6]=~crc[1], byte2[7]=~crc[0].
- CRC is computed combinationally from the latched field, or in the same cycle as the latch. The latency above must not change.
- Back-to-back requests: the earliest next start is the IDLE cycle after DONE.

Optional Feature:
- Macro USB_TOKEN_TX_LAST_EN.
- When defined, the block adds output utmi_tx_last (1 bit). It is high together with valid only while BYTE2 is driven, and 0 at reset.
- When undefined, the port does not exist and behaviour is otherwise identical.

Decomposition:
- Package usb_token_pkg holds:
  - token_type encodings TOK_OUT/TOK_IN/TOK_SOF/TOK_SETUP;
  - 4-bit PID constants (OUT=4'h1, IN=4'h9, SOF=4'h5, SETUP=4'hD);
  - the CRC5 polynomial and init value;
  - the FSM state typedef.
- One sub-module, usb_crc5: combinational 11-bit in, 5-bit transmit-ordered CRC out.

Test Plan:
- SETUP, addr=0, endp=0, ready=1 → bytes 0x2D, 0x00, 0x10 on three consecutive cycles starting the cycle after start; token_done pulses for one cycle afterwards.
- IN, addr=1, endp=1 → 0x69, 0x81, 0x58; token_ready=0 from the start until the cycle after done.
- SOF, frame=123 → 0xA5, 0x7B, 0x10; addr/endp values are ignored.
- OUT, addr=5, endp=2 with utmi_tx_ready toggled 0/1 → 0xE1, 0x05, 0xF9. Each byte is held stable while ready=0, and no byte is duplicated or skipped.
- Second condition:
  - Reset mid-packet after the PID is accepted → valid=0 and ready=1 the next cycle, and no done pulse.
  - token_start asserted mid-packet → ignored, and the packet completes unchanged.
- With USB_TOKEN_TX_LAST_EN defined: utmi_tx_last=1 only while byte2 is driven.
